// File: rtl/ps2_key_scheduler.sv
// PS/2 set-2 decoder for Enter/Left/Right with last-pressed-wins direction arbitration.
// Define AUTO_REPEAT_EN to build the timed auto-repeat counter; otherwise pulses fire on makes only.
module ps2_key_scheduler #(
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter int unsigned CNT_W        = 25
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       enter_pulse,
  output logic       left_pulse,
  output logic       right_pulse,
  output logic       enter_held,
  output logic       left_held,
  output logic       right_held,
  output logic [1:0] active_dir
);

  localparam logic [1:0] DirNone  = 2'b00;
  localparam logic [1:0] DirLeft  = 2'b01;
  localparam logic [1:0] DirRight = 2'b10;

  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeBrk   = 8'hF0;
  localparam logic [7:0] CodeEnter = 8'h5A;
  localparam logic [7:0] CodeLeft  = 8'h6B;
  localparam logic [7:0] CodeRight = 8'h74;

  localparam int unsigned MaxPeriod = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;

  if (REPEAT_DELAY < 2 || REPEAT_RATE < 2 || (64'd1 << CNT_W) <= 64'(MaxPeriod))
  begin : g_param_check
    $error("ps2_key_scheduler: invalid REPEAT_DELAY / REPEAT_RATE / CNT_W");
  end

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e     state_q, state_d;
  logic       enter_pulse_q, left_pulse_q, right_pulse_q;
  logic       enter_held_q, left_held_q, right_held_q;
  logic [1:0] active_q;

  logic ev_enter_mk, ev_enter_brk, ev_left_mk, ev_left_brk, ev_right_mk, ev_right_brk;
  logic enter_fresh, left_fresh, right_fresh, left_rel_active, right_rel_active;
  logic rep_fire;

  always_comb begin
    state_d      = state_q;
    ev_enter_mk  = 1'b0;
    ev_enter_brk = 1'b0;
    ev_left_mk   = 1'b0;
    ev_left_brk  = 1'b0;
    ev_right_mk  = 1'b0;
    ev_right_brk = 1'b0;
    if (received_data_en) begin
      unique case (state_q)
        StIdle: begin
          if (received_data == CodeExt)        state_d = StExt;
          else if (received_data == CodeBrk)   state_d = StBrk;
          else if (received_data == CodeEnter) ev_enter_mk = 1'b1;
        end
        StExt: begin
          state_d = StIdle;
          if (received_data == CodeBrk)        state_d = StExtBrk;
          else if (received_data == CodeExt)   state_d = StExt;
          else if (received_data == CodeLeft)  ev_left_mk = 1'b1;
          else if (received_data == CodeRight) ev_right_mk = 1'b1;
        end
        StBrk: begin
          state_d      = StIdle;
          ev_enter_brk = (received_data == CodeEnter);
        end
        StExtBrk: begin
          state_d      = StIdle;
          ev_left_brk  = (received_data == CodeLeft);
          ev_right_brk = (received_data == CodeRight);
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Makes of an already-held key are keyboard typematic and are dropped entirely.
  assign enter_fresh      = ev_enter_mk & ~enter_held_q;
  assign left_fresh       = ev_left_mk & ~left_held_q;
  assign right_fresh      = ev_right_mk & ~right_held_q;
  assign left_rel_active  = ev_left_brk & (active_q == DirLeft);
  assign right_rel_active = ev_right_brk & (active_q == DirRight);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= StIdle;
      enter_pulse_q <= 1'b0;
      left_pulse_q  <= 1'b0;
      right_pulse_q <= 1'b0;
      enter_held_q  <= 1'b0;
      left_held_q   <= 1'b0;
      right_held_q  <= 1'b0;
      active_q      <= DirNone;
    end else begin
      state_q       <= state_d;
      enter_pulse_q <= enter_fresh;
      left_pulse_q  <= left_fresh | (rep_fire & (active_q == DirLeft));
      right_pulse_q <= right_fresh | (rep_fire & (active_q == DirRight));

      if (enter_fresh)       enter_held_q <= 1'b1;
      else if (ev_enter_brk) enter_held_q <= 1'b0;
      if (left_fresh)        left_held_q  <= 1'b1;
      else if (ev_left_brk)  left_held_q  <= 1'b0;
      if (right_fresh)       right_held_q <= 1'b1;
      else if (ev_right_brk) right_held_q <= 1'b0;

      if (left_fresh)            active_q <= DirLeft;
      else if (right_fresh)      active_q <= DirRight;
      else if (left_rel_active)  active_q <= right_held_q ? DirRight : DirNone;
      else if (right_rel_active) active_q <= left_held_q ? DirLeft : DirNone;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] Delay = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] Rate  = CNT_W'(REPEAT_RATE);

  logic [CNT_W-1:0] cnt_q;
  logic             dir_owns, handover;

  // A direction event in the expiry cycle takes priority and supplies the reload.
  assign dir_owns = left_fresh | right_fresh | left_rel_active | right_rel_active;
  assign handover = (left_rel_active & right_held_q) | (right_rel_active & left_held_q);
  assign rep_fire = (active_q != DirNone) & (cnt_q == CNT_W'(1)) & ~dir_owns;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (left_fresh | right_fresh | handover) begin
      cnt_q <= Delay;
    end else if (left_rel_active | right_rel_active) begin
      cnt_q <= '0;
    end else if (active_q != DirNone && cnt_q != '0) begin
      cnt_q <= (cnt_q == CNT_W'(1)) ? Rate : cnt_q - CNT_W'(1);
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign enter_pulse = enter_pulse_q;
  assign left_pulse  = left_pulse_q;
  assign right_pulse = right_pulse_q;
  assign enter_held  = enter_held_q;
  assign left_held   = left_held_q;
  assign right_held  = right_held_q;
  assign active_dir  = active_q;

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Bench for ps2_key_scheduler: directed vector table, repeat-timing sequences and a
// randomized byte stream checked against a prefix/timestamp reference model.
module tb_ps2_key_scheduler;

  localparam int unsigned Delay = 8;
  localparam int unsigned Rate  = 4;
`ifdef AUTO_REPEAT_EN
  localparam bit Auto = 1'b1;
`else
  localparam bit Auto = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       enter_pulse, left_pulse, right_pulse;
  logic       enter_held, left_held, right_held;
  logic [1:0] active_dir;

  ps2_key_scheduler #(
    .REPEAT_DELAY(Delay),
    .REPEAT_RATE (Rate),
    .CNT_W       (4)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .enter_pulse     (enter_pulse),
    .left_pulse      (left_pulse),
    .right_pulse     (right_pulse),
    .enter_held      (enter_held),
    .left_held       (left_held),
    .right_held      (right_held),
    .active_dir      (active_dir)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending prefix bytes, held flags, active direction, absolute due cycle.
  logic [7:0] pfx[$];
  bit         m_eh, m_lh, m_rh;
  int         m_act, m_due, cyc;
  logic [7:0] m_exp;

  function automatic logic [7:0] obs();
    obs = {enter_pulse, left_pulse, right_pulse, enter_held, left_held, right_held, active_dir};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input logic [7:0] d);
    bit emk = 0, ebk = 0, lmk = 0, lbk = 0, rmk = 0, rbk = 0, dir_evt = 0;
    bit ep = 0, lp = 0, rp = 0;
    if (r) begin
      pfx.delete();
      m_eh = 0; m_lh = 0; m_rh = 0; m_act = 0;
      m_exp = 8'h00;
      return;
    end
    if (e) begin
      if (pfx.size() == 0) begin
        if (d == 8'hE0 || d == 8'hF0) pfx.push_back(d);
        else if (d == 8'h5A) emk = 1;
      end else if (pfx.size() == 1 && pfx[0] == 8'hE0) begin
        if (d == 8'hF0) pfx.push_back(d);
        else begin
          lmk = (d == 8'h6B);
          rmk = (d == 8'h74);
          if (d != 8'hE0) pfx.delete();
        end
      end else if (pfx.size() == 1) begin
        ebk = (d == 8'h5A);
        pfx.delete();
      end else begin
        lbk = (d == 8'h6B);
        rbk = (d == 8'h74);
        pfx.delete();
      end
    end
    if (emk && !m_eh) begin m_eh = 1; ep = 1; end
    if (ebk) m_eh = 0;
    if (lmk && !m_lh) begin m_lh = 1; m_act = 1; lp = 1; m_due = cyc + Delay; dir_evt = 1; end
    if (rmk && !m_rh) begin m_rh = 1; m_act = 2; rp = 1; m_due = cyc + Delay; dir_evt = 1; end
    if (lbk) begin
      m_lh = 0;
      if (m_act == 1) begin
        dir_evt = 1;
        if (m_rh) begin m_act = 2; m_due = cyc + Delay; end else m_act = 0;
      end
    end
    if (rbk) begin
      m_rh = 0;
      if (m_act == 2) begin
        dir_evt = 1;
        if (m_lh) begin m_act = 1; m_due = cyc + Delay; end else m_act = 0;
      end
    end
    if (Auto && !dir_evt && m_act != 0 && cyc == m_due) begin
      if (m_act == 1) lp = 1; else rp = 1;
      m_due = cyc + Rate;
    end
    m_exp = {ep, lp, rp, m_eh, m_lh, m_rh, 2'(m_act)};
  endtask

  // One clock cycle; outputs read afterwards reflect this cycle's inputs.
  task automatic step(input bit r, input bit e, input logic [7:0] d);
    reset = r;
    received_data_en = e;
    received_data = d;
    model_step(r, e, d);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    received_data_en = 1'b0;
    cyc++;
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vq[$];

  initial begin
    logic [7:0] codes[5];
    logic [7:0] d;
    bit         el, er;
    codes[0] = 8'hE0; codes[1] = 8'hF0; codes[2] = 8'h5A; codes[3] = 8'h6B; codes[4] = 8'h74;
    cyc = 0;
    m_due = 0;

    // {enter_p, left_p, right_p, enter_h, left_h, right_h, active_dir}
    vq.push_back('{1, 0, 8'h00, 8'h00});
    vq.push_back('{0, 1, 8'h5A, 8'h90});
    vq.push_back('{0, 0, 8'h00, 8'h10});
    vq.push_back('{0, 1, 8'h5A, 8'h10});
    vq.push_back('{0, 1, 8'hF0, 8'h10});
    vq.push_back('{0, 1, 8'h5A, 8'h00});
    vq.push_back('{0, 1, 8'hF0, 8'h00});
    vq.push_back('{0, 1, 8'hE0, 8'h00});
    vq.push_back('{0, 1, 8'h6B, 8'h00});
    vq.push_back('{0, 1, 8'hE0, 8'h00});
    vq.push_back('{1, 0, 8'h00, 8'h00});
    vq.push_back('{0, 1, 8'h6B, 8'h00});
    vq.push_back('{0, 1, 8'hE0, 8'h00});
    vq.push_back('{0, 1, 8'hE0, 8'h00});
    vq.push_back('{0, 1, 8'h6B, 8'h49});
    vq.push_back('{0, 1, 8'hE0, 8'h09});
    vq.push_back('{0, 1, 8'hF0, 8'h09});
    vq.push_back('{0, 1, 8'h6B, 8'h00});
    vq.push_back('{0, 1, 8'hE0, 8'h00});
    vq.push_back('{0, 1, 8'h5A, 8'h00});
    vq.push_back('{0, 1, 8'h5A, 8'h90});
    vq.push_back('{0, 1, 8'hF0, 8'h10});
    vq.push_back('{0, 1, 8'hE0, 8'h10});
    vq.push_back('{0, 1, 8'h5A, 8'h10});
    vq.push_back('{0, 1, 8'hF0, 8'h10});
    vq.push_back('{0, 1, 8'h5A, 8'h00});
    vq.push_back('{0, 1, 8'hE0, 8'h00});
    vq.push_back('{0, 1, 8'h74, 8'h26});
    vq.push_back('{1, 0, 8'h00, 8'h00});

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].en, vq[i].data);
      chk($sformatf("vec[%0d]", i), obs(), vq[i].exp);
    end

    // Hold Left: fresh pulse, first repeat after Delay, then every Rate.
    step(1, 0, 8'h00);
    step(0, 1, 8'hE0);
    step(0, 1, 8'h6B);
    chk("left_make", obs(), 8'h49);
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 8'h00);
      el = Auto && k >= 8 && ((k - 8) % 4 == 0);
      chk($sformatf("left_repeat k=%0d", k), {6'b0, left_pulse, right_pulse}, {6'b0, el, 1'b0});
    end
    // Right pressed over held Left, then released: handover without a pulse.
    step(0, 1, 8'hE0);
    step(0, 1, 8'h74);
    chk("right_over_left", obs(), 8'h2E);
    step(0, 1, 8'hE0);
    step(0, 1, 8'hF0);
    chk("right_brk_prefix", obs(), 8'h0E);
    step(0, 1, 8'h74);
    chk("handover_to_left", obs(), 8'h09);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 8'h00);
      el = Auto && k == 8;
      chk($sformatf("handover_repeat k=%0d", k), {6'b0, left_pulse, right_pulse}, {6'b0, el, 1'b0});
    end

    // Right make lands exactly on the Left repeat expiry.
    step(1, 0, 8'h00);
    step(0, 1, 8'hE0);
    step(0, 1, 8'h6B);
    chk("left_make2", obs(), 8'h49);
    for (int k = 1; k <= 6; k++) step(0, 0, 8'h00);
    step(0, 1, 8'hE0);
    step(0, 1, 8'h74);
    chk("coincide_pulses", {6'b0, left_pulse, right_pulse}, 8'h01);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 8'h00);
      er = Auto && k == 8;
      chk($sformatf("coincide_repeat k=%0d", k), {6'b0, left_pulse, right_pulse}, {7'b0, er});
    end

    // Random byte stream against the reference model.
    for (int i = 0; i < 1500; i++) begin
      bit r, e;
      r = ($urandom_range(0, 249) == 0);
      e = ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 5) == 0) ? 8'($urandom) : codes[$urandom_range(0, 4)];
      step(r, e, d);
      chk("random", obs(), m_exp);
      chk("pulse_exclusive", {7'b0, left_pulse & right_pulse}, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
